// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor sequencer.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// Single-bit combinational full adder shared across all bit positions.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ cin;
    assign c = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer: one full-adder cell, LSB first,
// carry registered between cycles, busy/done handshake around registered result.
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             c_msb_in;
    logic [CNT_W-1:0] idx;

    logic             cell_s;
    logic             cell_c;
    logic [WIDTH-1:0] acc_next;

    fa_cell u_fa (
        .x   (sa[0]),
        .y   (sb[0]),
        .cin (carry),
        .s   (cell_s),
        .c   (cell_c)
    );

    // Sum bits enter from the MSB side so the LSB lands in bit 0 after WIDTH shifts.
    assign acc_next = {cell_s, acc[WIDTH-1:1]};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
            sa       <= '0;
            sb       <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtract as A + ~B + 1: invert B here, inject the +1 as carry-in.
                        sa    <= a;
                        sb    <= b ^ {WIDTH{op}};
                        carry <= (op == OP_SUB);
                        idx   <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= cell_c;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    idx   <= idx + CNT_W'(1);
                    if (idx == CNT_W'(WIDTH - 2)) begin
                        c_msb_in <= cell_c;
                    end
                    if (idx == CNT_W'(WIDTH - 1)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= acc_next;
                        cout   <= cell_c;
                        ovf    <= c_msb_in ^ cell_c;
                        zero   <= (acc_next == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
